// File: rtl/nios_128k_extended_button_debounce.sv
// Push-button conditioner: two-flop synchroniser, per-bit stability-counter debounce,
// and registered single-cycle press/release strobes, all in the clk domain.
module nios_128k_extended_button_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] button_raw,
  output logic [WIDTH-1:0] button_clean,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam logic             ACT_LO  = (ACTIVE_LOW != 0);
  localparam logic [WIDTH-1:0] IDLE    = {WIDTH{ACT_LO}};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q1, sync_q2;
  logic [WIDTH-1:0] clean_q, clean_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] release_q, release_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Counter restarts on any sample matching the accepted level and clears on
  // acceptance, so it never exceeds CNT_MAX.
  always_comb begin
    clean_d   = clean_q;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      if (sync_q2[i] == clean_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        clean_d[i] = sync_q2[i];
        cnt_d[i]   = '0;
        if (sync_q2[i] != ACT_LO) press_d[i] = 1'b1;
        else                      release_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1   <= IDLE;
      sync_q2   <= IDLE;
      clean_q   <= IDLE;
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync_q1   <= button_raw;
      sync_q2   <= sync_q1;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign button_clean  = clean_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_nios_128k_extended_button_debounce.sv
// Directed bench for the button debouncer with WIDTH=4, DEBOUNCE_CYCLES=8, ACTIVE_LOW=1.
module tb_nios_128k_extended_button_debounce;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] button_raw = 4'hF;
  logic [3:0] button_clean, press_pulse, release_pulse;

  int tests = 0;
  int fails = 0;

  nios_128k_extended_button_debounce #(
    .WIDTH(4), .DEBOUNCE_CYCLES(8), .CNT_W(19), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .button_raw(button_raw),
    .button_clean(button_clean), .press_pulse(press_pulse), .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // raw is driven before the first edge of the row; intermediate edges must show
  // hold_clean and no pulses, the last edge must show the exp_* values.
  typedef struct {
    logic [3:0] raw;
    int         ticks;
    logic [3:0] hold_clean;
    logic [3:0] exp_clean;
    logic [3:0] exp_press;
    logic [3:0] exp_release;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    button_raw = v.raw;
    for (int t = 0; t < v.ticks; t++) begin
      tick();
      if (t < v.ticks - 1) begin
        check({tag, ".hold_clean"}, button_clean, v.hold_clean);
        check({tag, ".hold_press"}, press_pulse, 4'h0);
        check({tag, ".hold_release"}, release_pulse, 4'h0);
      end else begin
        check({tag, ".clean"}, button_clean, v.exp_clean);
        check({tag, ".press"}, press_pulse, v.exp_press);
        check({tag, ".release"}, release_pulse, v.exp_release);
      end
    end
  endtask

  initial begin
    // Clean press on bit0, press bit2, simultaneous release of bits 0 and 2
    vecs.push_back('{4'hE, 9, 4'hF, 4'hF, 4'h0, 4'h0});
    vecs.push_back('{4'hE, 1, 4'hF, 4'hE, 4'h1, 4'h0});
    vecs.push_back('{4'hE, 1, 4'hE, 4'hE, 4'h0, 4'h0});
    vecs.push_back('{4'hA, 9, 4'hE, 4'hE, 4'h0, 4'h0});
    vecs.push_back('{4'hA, 1, 4'hE, 4'hA, 4'h4, 4'h0});
    vecs.push_back('{4'hA, 1, 4'hA, 4'hA, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 9, 4'hA, 4'hA, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 1, 4'hA, 4'hF, 4'h0, 4'h5});
    vecs.push_back('{4'hF, 1, 4'hF, 4'hF, 4'h0, 4'h0});
    // 7-cycle glitch on bit3 is rejected
    vecs.push_back('{4'h7, 7, 4'hF, 4'hF, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 20, 4'hF, 4'hF, 4'h0, 4'h0});
    // 8-cycle low on bit3 is accepted, then released 8 cycles later
    vecs.push_back('{4'h7, 8, 4'hF, 4'hF, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 1, 4'hF, 4'hF, 4'h0, 4'h0});
    vecs.push_back('{4'hF, 1, 4'hF, 4'h7, 4'h8, 4'h0});
    vecs.push_back('{4'hF, 8, 4'h7, 4'hF, 4'h0, 4'h8});
    vecs.push_back('{4'hF, 10, 4'hF, 4'hF, 4'h0, 4'h0});

    // Outputs during reset
    repeat (3) tick();
    check("in_reset.clean", button_clean, 4'hF);
    check("in_reset.press", press_pulse, 4'h0);
    check("in_reset.release", release_pulse, 4'h0);
    reset_n = 1'b1;
    apply('{4'hF, 50, 4'hF, 4'hF, 4'h0, 4'h0}, "post_reset");

    foreach (vecs[k]) apply(vecs[k], $sformatf("vec%0d", k));

    // Bounce on bit1: runs of 3 cycles alternating low/high for 40 cycles
    for (int t = 0; t < 40; t++) begin
      button_raw = ((t / 3) % 2 == 0) ? 4'hD : 4'hF;
      tick();
      check("bounce.clean", button_clean, 4'hF);
      check("bounce.press", press_pulse, 4'h0);
      check("bounce.release", release_pulse, 4'h0);
    end
    apply('{4'hD, 9, 4'hF, 4'hF, 4'h0, 4'h0}, "bounce_settle");
    apply('{4'hD, 1, 4'hF, 4'hD, 4'h2, 4'h0}, "bounce_accept");
    apply('{4'hD, 1, 4'hD, 4'hD, 4'h0, 4'h0}, "bounce_after");
    apply('{4'hF, 9, 4'hD, 4'hD, 4'h0, 4'h0}, "bounce_rel_wait");
    apply('{4'hF, 1, 4'hD, 4'hF, 4'h0, 4'h2}, "bounce_rel");
    apply('{4'hF, 3, 4'hF, 4'hF, 4'h0, 4'h0}, "bounce_quiet");

    // Reset mid-count on bit0, asserted away from the clock edge
    apply('{4'hE, 5, 4'hF, 4'hF, 4'h0, 4'h0}, "midcnt");
    #2 reset_n = 1'b0;
    #1;
    check("midcnt_rst.clean", button_clean, 4'hF);
    check("midcnt_rst.press", press_pulse, 4'h0);
    check("midcnt_rst.release", release_pulse, 4'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    apply('{4'hE, 9, 4'hF, 4'hF, 4'h0, 4'h0}, "midcnt_wait");
    apply('{4'hE, 1, 4'hF, 4'hE, 4'h1, 4'h0}, "midcnt_accept");
    apply('{4'hE, 1, 4'hE, 4'hE, 4'h0, 4'h0}, "midcnt_after");

    // Reset while a press is accepted: level returns to IDLE with no clock
    #2 reset_n = 1'b0;
    #1;
    check("accepted_rst.clean", button_clean, 4'hF);
    check("accepted_rst.press", press_pulse, 4'h0);
    check("accepted_rst.release", release_pulse, 4'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    apply('{4'hE, 9, 4'hF, 4'hF, 4'h0, 4'h0}, "rearm_wait");
    apply('{4'hE, 1, 4'hF, 4'hE, 4'h1, 4'h0}, "rearm_accept");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
